// File: rtl/hdmi_fetch_scheduler_if.sv
// rtl/hdmi_fetch_scheduler_if.sv - AXI read-address channel plus pixel FIFO beat/pop strobes
interface hdmi_fetch_scheduler_if;
  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [31:0] ar_addr_o;
  logic [7:0]  ar_len_o;
  logic        r_beat_i;
  logic        fifo_pop_i;

  modport master (
    output ar_valid_o, ar_addr_o, ar_len_o,
    input  ar_ready_i, r_beat_i, fifo_pop_i
  );

  modport slave (
    input  ar_valid_o, ar_addr_o, ar_len_o,
    output ar_ready_i, r_beat_i, fifo_pop_i
  );
endinterface

// File: rtl/hdmi_fetch_scheduler.sv
// rtl/hdmi_fetch_scheduler.sv - credit-throttled frame fetch sequencer; HDMI_FETCH_4K_BOUNDARY_EN splits bursts at 4 KB
module hdmi_fetch_scheduler #(
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] stride_i,
  input  logic [11:0] hres_i,
  input  logic [11:0] vres_i,
  input  logic [1:0]  bitcfg_i,
  input  logic        vsync_i,
  output logic        flush_o,
  output logic        frame_done_o,
  output logic        overrun_o,
  output logic        busy_o,
  hdmi_fetch_scheduler_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, FLUSH, FETCH, LINE_END, DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     stride_q, stride_d;
  logic [11:0]     hres_q, hres_d, vres_q, vres_d, line_cnt_q, line_cnt_d;
  logic            bpp16_q, bpp16_d;
  logic [31:0]     line_addr_q, line_addr_d, addr_q, addr_d;
  logic [13:0]     remaining_q, remaining_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [15:0]     outstanding_q, outstanding_d;
  logic            flush_q, flush_d, ar_valid_q, ar_valid_d;
  logic [31:0]     ar_addr_q, ar_addr_d;
  logic [7:0]      ar_len_q, ar_len_d;
  logic            frame_done_q, frame_done_d, overrun_q, overrun_d, busy_q, busy_d;
  logic            hs, hold;
  logic [13:0]     hs_beats, beats_n;
`ifdef HDMI_FETCH_4K_BOUNDARY_EN
  logic [13:0]     bound_n;
`endif
  logic            unused_bitcfg;

  // Colour-mode bit 0 carries no meaning here.
  assign unused_bitcfg = bitcfg_i[0];

  function automatic logic [13:0] calc_line_words(input logic [11:0] h, input logic bpp16);
    logic [13:0] h14;
    h14 = {2'b00, h};
    if (bpp16) return (h14 + 14'd1) >> 1;
    return (h14 * 14'd3 + 14'd3) >> 2;
  endfunction

  assign bus.ar_valid_o = ar_valid_q;
  assign bus.ar_addr_o  = ar_addr_q;
  assign bus.ar_len_o   = ar_len_q;
  assign flush_o        = flush_q;
  assign frame_done_o   = frame_done_q;
  assign overrun_o      = overrun_q;
  assign busy_o         = busy_q;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d       = state_q;
    stride_d      = stride_q;
    hres_d        = hres_q;
    vres_d        = vres_q;
    bpp16_d       = bpp16_q;
    line_addr_d   = line_addr_q;
    addr_d        = addr_q;
    line_cnt_d    = line_cnt_q;
    remaining_d   = remaining_q;
    ar_valid_d    = ar_valid_q;
    ar_addr_d     = ar_addr_q;
    ar_len_d      = ar_len_q;
    overrun_d     = overrun_q;
    beats_n       = '0;

    hs       = ar_valid_q && bus.ar_ready_i;
    hold     = ar_valid_q && !bus.ar_ready_i;
    hs_beats = 14'(ar_len_q) + 14'd1;

    credits_d = credits_q - (hs ? CW'(hs_beats) : CW'(0)) + (bus.fifo_pop_i ? CW'(1) : CW'(0));
    outstanding_d = outstanding_q + (hs ? 16'(hs_beats) : 16'd0) - (bus.r_beat_i ? 16'd1 : 16'd0);

    if (state_q == IDLE) begin
      overrun_d = 1'b0;
    end else if (vsync_i && (state_q == FLUSH || state_q == FETCH || state_q == LINE_END)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable_i && vsync_i) state_d = FLUSH;
      end
      FLUSH: begin
        stride_d    = stride_i & 16'hFFFC;
        hres_d      = hres_i;
        vres_d      = vres_i;
        bpp16_d     = bitcfg_i[1];
        line_addr_d = base_addr_i & 32'hFFFF_FFFC;
        addr_d      = base_addr_i & 32'hFFFF_FFFC;
        line_cnt_d  = '0;
        remaining_d = calc_line_words(hres_i, bitcfg_i[1]);
        credits_d   = CW'(FIFO_DEPTH);
        if (!enable_i) state_d = IDLE;
        else if (hres_i == 12'd0 || vres_i == 12'd0) state_d = DONE;
        else state_d = FETCH;
      end
      FETCH: begin
        if (hs) begin
          addr_d      = addr_q + {16'd0, hs_beats, 2'b00};
          remaining_d = remaining_q - hs_beats;
          ar_valid_d  = 1'b0;
          if (!enable_i) state_d = IDLE;
          else if (remaining_d == 14'd0) state_d = LINE_END;
        end else if (!ar_valid_q && !enable_i) begin
          state_d = IDLE;
        end
      end
      LINE_END: begin
        line_cnt_d  = line_cnt_q + 12'd1;
        line_addr_d = line_addr_q + {16'd0, stride_q};
        addr_d      = line_addr_q + {16'd0, stride_q};
        remaining_d = calc_line_words(hres_q, bpp16_q);
        if (!enable_i) state_d = IDLE;
        else if (line_cnt_q == vres_q - 12'd1) state_d = DONE;
        else state_d = FETCH;
      end
      DONE: begin
        if (!enable_i) state_d = IDLE;
        else if (vsync_i) state_d = FLUSH;
      end
      default: state_d = IDLE;
    endcase

    // A request is (re)armed from the post-update pointer so bursts can run back to back.
    beats_n = (remaining_d < 14'(MAX_BURST)) ? remaining_d : 14'(MAX_BURST);
`ifdef HDMI_FETCH_4K_BOUNDARY_EN
    bound_n = 14'((13'h1000 - {1'b0, addr_d[11:0]}) >> 2);
    if (bound_n < beats_n) beats_n = bound_n;
`endif
    if (state_d == FETCH && !hold) begin
      ar_valid_d = (remaining_d != 14'd0) && (16'(credits_d) >= 16'(beats_n));
      if (ar_valid_d) begin
        ar_addr_d = addr_d;
        ar_len_d  = 8'(beats_n - 14'd1);
      end
    end else if (state_d != FETCH) begin
      ar_valid_d = 1'b0;
    end

    flush_d      = (state_d == FLUSH);
    frame_done_d = (state_d == DONE) && (state_q != DONE);
    busy_d       = (state_d != IDLE) || (outstanding_d != 16'd0);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      stride_q      <= '0;
      hres_q        <= '0;
      vres_q        <= '0;
      bpp16_q       <= 1'b0;
      line_addr_q   <= '0;
      addr_q        <= '0;
      line_cnt_q    <= '0;
      remaining_q   <= '0;
      credits_q     <= '0;
      outstanding_q <= '0;
      flush_q       <= 1'b0;
      ar_valid_q    <= 1'b0;
      ar_addr_q     <= '0;
      ar_len_q      <= '0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stride_q      <= stride_d;
      hres_q        <= hres_d;
      vres_q        <= vres_d;
      bpp16_q       <= bpp16_d;
      line_addr_q   <= line_addr_d;
      addr_q        <= addr_d;
      line_cnt_q    <= line_cnt_d;
      remaining_q   <= remaining_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      flush_q       <= flush_d;
      ar_valid_q    <= ar_valid_d;
      ar_addr_q     <= ar_addr_d;
      ar_len_q      <= ar_len_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end
endmodule

// File: tb/tb_hdmi_fetch_scheduler.sv
// tb/tb_hdmi_fetch_scheduler.sv - scoreboard bench for hdmi_fetch_scheduler
module tb_hdmi_fetch_scheduler;
  logic        clk;
  logic        rst;
  logic        enable_i;
  logic [31:0] base_addr_i;
  logic [15:0] stride_i;
  logic [11:0] hres_i;
  logic [11:0] vres_i;
  logic [1:0]  bitcfg_i;
  logic        vsync_i;
  logic        flush_o;
  logic        frame_done_o;
  logic        overrun_o;
  logic        busy_o;

  hdmi_fetch_scheduler_if bus ();

  hdmi_fetch_scheduler #(.FIFO_DEPTH(64), .MAX_BURST(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .base_addr_i  (base_addr_i),
    .stride_i     (stride_i),
    .hres_i       (hres_i),
    .vres_i       (vres_i),
    .bitcfg_i     (bitcfg_i),
    .vsync_i      (vsync_i),
    .flush_o      (flush_o),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o),
    .bus          (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [39:0] exp_q[$];

  // Memory/FIFO model state.
  int pend       = 0;
  int fifo_cnt   = 0;
  int pop_budget = 0;
  logic pop_en = 1'b1;
  logic r_en   = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    exp_q.push_back({a, l});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [15:0] s, input logic [11:0] h,
                             input logic [11:0] v, input logic [1:0] c);
    base_addr_i = b;
    stride_i    = s;
    hres_i      = h;
    vres_i      = v;
    bitcfg_i    = c;
    enable_i    = 1'b1;
    vsync_i     = 1'b1;
    cyc(1);
    vsync_i     = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_cnt < 1) && n < 2000) begin
      cyc(1);
      n++;
    end
    cyc(4);
    check({name, "_ars_left"}, exp_q.size(), 0);
    check({name, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic go_idle(input string name);
    int n;
    enable_i = 1'b0;
    pop_en   = 1'b1;
    r_en     = 1'b1;
    n = 0;
    cyc(1);
    while (busy_o && n < 500) begin
      cyc(1);
      n++;
    end
    check({name, "_busy_clear"}, busy_o, 0);
    done_cnt = 0;
  endtask

  // Scoreboard monitor: every AR handshake is compared against the oldest expectation.
  initial begin : monitor
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_done_o) done_cnt++;
        if (bus.ar_valid_o && bus.ar_ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL ar_unexpected: got addr 0x%08h len %0d, required no AR", bus.ar_addr_o, bus.ar_len_o);
          end else begin
            e = exp_q.pop_front();
            check("ar_addr", bus.ar_addr_o, e[39:8]);
            check("ar_len", {24'd0, bus.ar_len_o}, {24'd0, e[7:0]});
          end
        end
      end
    end
  end

  // Read-data and FIFO model: one R beat per cycle for accepted bursts, pops while words are held.
  initial begin : bfm
    bus.r_beat_i   = 1'b0;
    bus.fifo_pop_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.ar_valid_o && bus.ar_ready_i) pend += int'(bus.ar_len_o) + 1;
        if (bus.r_beat_i) begin
          pend--;
          fifo_cnt++;
        end
        if (bus.fifo_pop_i) begin
          fifo_cnt--;
          if (!pop_en && pop_budget > 0) pop_budget--;
        end
      end
      @(posedge clk);
      #1;
      bus.r_beat_i   = r_en && (pend > 0);
      bus.fifo_pop_i = (fifo_cnt > 0) && (pop_en || pop_budget > 0);
    end
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    enable_i = 1'b0;
    base_addr_i = '0;
    stride_i = '0;
    hres_i = '0;
    vres_i = '0;
    bitcfg_i = '0;
    vsync_i = 1'b0;
    bus.ar_ready_i = 1'b1;
    cyc(3);
    check("rst_ar_valid", bus.ar_valid_o, 0);
    check("rst_ar_addr", bus.ar_addr_o, 0);
    check("rst_ar_len", {24'd0, bus.ar_len_o}, 0);
    check("rst_flags", {28'd0, flush_o, frame_done_o, overrun_o, busy_o}, 0);
    rst = 1'b0;
    cyc(2);

    // 16 bpp, two lines of two bursts each.
    push_ar(32'h1000, 8'd15);
    push_ar(32'h1040, 8'd15);
    push_ar(32'h1100, 8'd15);
    push_ar(32'h1140, 8'd15);
    start_frame(32'h1000, 16'h0100, 12'd64, 12'd2, 2'b10);
    check("t1_flush", flush_o, 1);
    check("t1_no_ar_yet", bus.ar_valid_o, 0);
    cyc(1);
    check("t1_flush_one_cycle", flush_o, 0);
    check("t1_ar_earliest", bus.ar_valid_o, 1);
    wait_frame("t1");
    go_idle("t1");

    // 24 bpp ragged tail; low address/stride bits ignored, bitcfg bit 0 ignored.
    push_ar(32'h2000, 8'd7);
    push_ar(32'h2040, 8'd7);
    start_frame(32'h2003, 16'h0043, 12'd10, 12'd2, 2'b01);
    wait_frame("t2");
    go_idle("t2");

    // Burst near a 4 KB boundary.
`ifdef HDMI_FETCH_4K_BOUNDARY_EN
    push_ar(32'h0FF0, 8'd3);
    push_ar(32'h1000, 8'd11);
`else
    push_ar(32'h0FF0, 8'd15);
`endif
    start_frame(32'h0FF0, 16'h0000, 12'd32, 12'd1, 2'b10);
    wait_frame("t4k");
    go_idle("t4k");

    // Credit stall with no pops.
    pop_en = 1'b0;
    push_ar(32'h3000, 8'd15);
    push_ar(32'h3040, 8'd15);
    push_ar(32'h3080, 8'd15);
    push_ar(32'h30C0, 8'd15);
    start_frame(32'h3000, 16'h0000, 12'd256, 12'd1, 2'b10);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin cyc(1); n++; end
    cyc(80);
    check("stall_four_issued", exp_q.size(), 0);
    check("stall_valid_low", bus.ar_valid_o, 0);
    pop_budget = 1;
    cyc(6);
    check("stall_one_pop", bus.ar_valid_o, 0);
    pop_budget = 14;
    cyc(24);
    check("stall_fifteen_pops", bus.ar_valid_o, 0);
    push_ar(32'h3100, 8'd15);
    pop_budget = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin cyc(1); n++; end
    check("stall_resume", exp_q.size(), 0);
    push_ar(32'h3140, 8'd15);
    push_ar(32'h3180, 8'd15);
    push_ar(32'h31C0, 8'd15);
    pop_en = 1'b1;
    wait_frame("stall");
    go_idle("stall");

    // vsync mid-FETCH sets overrun but the frame completes.
    push_ar(32'h1000, 8'd15);
    push_ar(32'h1040, 8'd15);
    push_ar(32'h1100, 8'd15);
    push_ar(32'h1140, 8'd15);
    start_frame(32'h1000, 16'h0100, 12'd64, 12'd2, 2'b10);
    cyc(1);
    vsync_i = 1'b1;
    cyc(1);
    vsync_i = 1'b0;
    check("ovr_set", overrun_o, 1);
    wait_frame("ovr");
    check("ovr_sticky", overrun_o, 1);
    go_idle("ovr");
    check("ovr_cleared_idle", overrun_o, 0);

    // Disable while AR pending: request held, then IDLE, busy until beats return.
    bus.ar_ready_i = 1'b0;
    r_en = 1'b0;
    start_frame(32'h5000, 16'h0100, 12'd64, 12'd1, 2'b10);
    cyc(1);
    enable_i = 1'b0;
    cyc(3);
    check("dis_valid_held", bus.ar_valid_o, 1);
    check("dis_addr_held", bus.ar_addr_o, 32'h5000);
    check("dis_len_held", {24'd0, bus.ar_len_o}, 32'd15);
    push_ar(32'h5000, 8'd15);
    bus.ar_ready_i = 1'b1;
    cyc(1);
    check("dis_valid_drop", bus.ar_valid_o, 0);
    cyc(3);
    check("dis_busy_outstanding", busy_o, 1);
    check("dis_no_more_ar", exp_q.size(), 0);
    go_idle("dis");

    // Asynchronous reset mid-burst.
    bus.ar_ready_i = 1'b0;
    start_frame(32'h6000, 16'h0100, 12'd64, 12'd1, 2'b10);
    cyc(1);
    vsync_i = 1'b1;
    cyc(1);
    vsync_i = 1'b0;
    check("rst_pre_overrun", overrun_o, 1);
    check("rst_pre_valid", bus.ar_valid_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ar_valid", bus.ar_valid_o, 0);
    check("arst_ar_addr", bus.ar_addr_o, 0);
    check("arst_flags", {28'd0, flush_o, frame_done_o, overrun_o, busy_o}, 0);
    enable_i = 1'b0;
    pend = 0;
    fifo_cnt = 0;
    pop_budget = 0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    done_cnt = 0;
    bus.ar_ready_i = 1'b1;
    cyc(2);

    // Scanout resumes normally after reset.
    push_ar(32'h7000, 8'd7);
    start_frame(32'h7000, 16'h0000, 12'd10, 12'd1, 2'b00);
    wait_frame("post_rst");
    go_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hdmi_fetch_scheduler.md
# hdmi_fetch_scheduler

Frame-fetch sequencer for the HDMI output path. On each vertical sync it flushes the pixel converter and walks the framebuffer line by line. It issues AXI read bursts into the 32-bit pixel word FIFO that feeds the converter, and throttles issue with a credit counter so the FIFO can never overflow.

## Interface
- `FIFO_DEPTH`, 64: pixel word FIFO depth in 32-bit words; power of two, ≥ `MAX_BURST`.
- `MAX_BURST`, 16: maximum beats per AR request, 1..256.
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-high reset.
- `enable_i` input 1: scanout enable.
- `base_addr_i` input 32: framebuffer base in bytes; bits [1:0] ignored and forced to 0.
- `stride_i` input 16: line pitch in bytes; bits [1:0] ignored and forced to 0.
- `hres_i` input 12: active pixels per line.
- `vres_i` input 12: active lines per frame.
- `bitcfg_i` input 2: colour mode. Bit 1 = 1 selects 16 bpp; otherwise 24 bpp packed.
- `vsync_i` input 1: single-cycle frame-start pulse from the timing generator.
- `flush_o` output 1: one-cycle flush to the pixel converter and FIFO.
- `ar_valid_o` output 1: AXI AR valid.
- `ar_ready_i` input 1: AXI AR ready.
- `ar_addr_o` output 32: burst byte address, word aligned.
- `ar_len_o` output 8: beats−1.
- `r_beat_i` input 1: one R beat accepted into the FIFO.
- `fifo_pop_i` input 1: converter popped one FIFO word.
- `frame_done_o` output 1: one-cycle pulse after the last AR of a frame is issued.
- `overrun_o` output 1: sticky flag, set when `vsync_i` arrives mid-frame.
- `busy_o` output 1: high while state ≠ IDLE or read beats are still outstanding.

## Operation
- **Words per line (`line_words`, 14 bits):**
  - 16 bpp: (hres+1)>>1.
  - 24 bpp: (3·hres+3)>>2.
- **Config latch:** `base_addr_i`, `stride_i`, `hres_i`, `vres_i` and `bitcfg_i` are latched in FLUSH and held for the whole frame.
- **Credits** (width log2(FIFO_DEPTH)+1):
  - Set to FIFO_DEPTH in FLUSH.
  - −(len+1) on each AR handshake.
  - +1 on each `fifo_pop_i`.
  - A handshake and a pop in the same cycle apply both.
- **Outstanding beats:** +(len+1) on each AR handshake, −1 on each `r_beat_i`. Not cleared by FLUSH.
- **Burst length:** beats = min(MAX_BURST, remaining words in line, boundary limit). `ar_len_o` = beats−1.
- **States:**
  - **IDLE:** waits for `enable_i` && `vsync_i`, then → FLUSH.
  - **FLUSH:** `flush_o`=1 for exactly one cycle. Latches config, sets line_addr = base, line_cnt = 0, remaining = `line_words`. If hres==0 or vres==0 → DONE; otherwise → FETCH.
  - **FETCH:** asserts `ar_valid_o` only when credits ≥ beats. Once asserted, `ar_valid_o`, `ar_addr_o` and `ar_len_o` stay stable until `ar_ready_i`. On handshake: addr += 4·beats, remaining −= beats. If remaining reaches 0 → LINE_END.
  - **LINE_END:** one cycle. line_cnt += 1, line_addr += stride, addr = new line_addr, remaining = `line_words`. If line_cnt == vres−1 before the increment → DONE; otherwise → FETCH.
  - **DONE:** `frame_done_o` pulses on the entry cycle. On `vsync_i` → FLUSH if `enable_i` is high, otherwise → IDLE.
- **`enable_i` deasserted:**
  - In FETCH with `ar_valid_o` high: complete that handshake, then → IDLE.
  - In any other non-IDLE state: → IDLE next cycle.
- **`vsync_i` in FLUSH, FETCH or LINE_END:** sets `overrun_o` and is otherwise ignored; the frame completes. `overrun_o` clears only on reset or in IDLE.
- **Address arithmetic:** 32-bit, wraps modulo 2^32.

## Timing
- Reset values: `flush_o`, `ar_valid_o`, `frame_done_o`, `overrun_o` and `busy_o` = 0; `ar_addr_o` = 0; `ar_len_o` = 0; state = IDLE; all counters = 0.
- `vsync_i` in IDLE or DONE → `flush_o` at cycle +1.
- Earliest `ar_valid_o`: cycle +2 after `vsync_i`.
- Back-to-back ARs with `ar_ready_i` tied high: one per cycle within a line, plus one idle cycle per line for LINE_END.
- A pop restores a credit in the cycle after `fifo_pop_i`.
- All outputs are registered.

## Configuration
- Macro: `HDMI_FETCH_4K_BOUNDARY_EN`.
- **Defined:** the boundary limit is (4096 − addr[11:0])>>2, so no burst crosses a 4 KB boundary.
- **Undefined:** there is no boundary term, and software guarantees that base and stride keep each line's bursts within 4 KB.

## Test plan
- **16 bpp:** hres=64, vres=2, base=0x1000, stride=0x100, ar_ready=1, FIFO popped continuously → ARs at 0x1000/len 15, 0x1040/len 15, 0x1100/len 15, 0x1140/len 15; one `frame_done_o` pulse.
- **24 bpp, ragged tail:** hres=10 → line_words=8 → a single AR with len 7 per line.
- **Credit stall:** FIFO_DEPTH=64, no pops → exactly 4 ARs of 16 beats, then `ar_valid_o` stays low. One pop does not unstall; 16 pops → the next AR appears.
- **4 KB split, macro defined:** base=0x0FF0, hres=32 at 16 bpp → AR 0x0FF0 len 3, then AR 0x1000 len 11. With the macro undefined → a single AR with len 15.
- **Overrun and reset:**
  - `vsync_i` mid-FETCH → `overrun_o`=1 and the frame still completes.
  - `rst` asserted mid-burst → all outputs 0 immediately, without waiting for a clock edge.
- **Disable:** `enable_i` deasserted while AR is valid and `ar_ready_i`=0 → AR held stable until ready, then IDLE. `busy_o` stays high until all outstanding `r_beat_i` have arrived.
